// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and frame types for the UART command decoder
package uart_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         ERR_CNT_W     = 8;

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_CHK  = 2'd3;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } frame_t;

   // The sync byte seeds the checksum, so a frame XORs to zero over all four bytes
   function automatic logic [7:0] frame_chk(input logic [7:0] seed,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
      return seed ^ addr ^ data;
   endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// rtl/uart_frame_timer.sv - inter-byte timeout counter clocked by the baud oversample tick
module uart_frame_timer #(
   parameter int TIMEOUT_TICKS = 320,
   parameter int TMR_W         = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   input  logic baud_tick,
   output logic expired
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_TICKS - 1);

   logic [TMR_W-1:0] cnt;

   assign expired = enable && baud_tick && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || expired) begin
         cnt <= '0;
      end else if (enable && baud_tick) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - extracts SYNC/ADDR/DATA/CHK frames into register-write commands
module uart_cmd_decoder
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_TICKS = 320,
   parameter int         TMR_W         = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           cmd_addr,
   output logic [7:0]           cmd_data,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [1:0] state;
   frame_t     frame_q;
   logic       expired;
   logic       timeout;
   logic       chk_strobe;
   logic       chk_good;
   logic       load_cmd;
   logic       overrun;
   logic       bad_chk;
   logic       err_evt;

   uart_frame_timer #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS),
      .TMR_W        (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (rx_valid || (state == ST_HUNT)),
      .enable   (state != ST_HUNT),
      .baud_tick(baud_tick),
      .expired  (expired)
   );

   // A byte arriving on the expiring tick takes precedence over the timeout
   assign timeout    = expired && !rx_valid;
   assign chk_strobe = rx_valid && (state == ST_CHK);
   assign chk_good   = (rx_data == frame_chk(SYNC_BYTE, frame_q.addr, frame_q.data));
   assign load_cmd   = chk_strobe && chk_good && (!cmd_valid || cmd_ready);
   assign overrun    = chk_strobe && chk_good && cmd_valid && !cmd_ready;
   assign bad_chk    = chk_strobe && !chk_good;
   assign err_evt    = bad_chk || overrun || timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_HUNT;
         frame_q <= '0;
      end else if (rx_valid) begin
         case (state)
            ST_HUNT: if (rx_data == SYNC_BYTE) state <= ST_ADDR;
            ST_ADDR: begin
               frame_q.addr <= rx_data;
               state        <= ST_DATA;
            end
            ST_DATA: begin
               frame_q.data <= rx_data;
               state        <= ST_CHK;
            end
            default: state <= ST_HUNT;
         endcase
      end else if (timeout) begin
         state <= ST_HUNT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_addr  <= '0;
         cmd_data  <= '0;
         cmd_valid <= 1'b0;
      end else if (load_cmd) begin
         cmd_addr  <= frame_q.addr;
         cmd_data  <= frame_q.data;
         cmd_valid <= 1'b1;
      end else if (cmd_valid && cmd_ready) begin
         cmd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         frame_err <= err_evt;
         if (err_evt && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule
